// File: rtl/period_ramp_ctrl.sv
// period_ramp_ctrl: slews an oscillator period word toward an accepted target.
// The word moves by at most one step every UPDATE_DIV clocks, so the
// oscillator frequency changes smoothly instead of jumping.
//
// Ports:
//   CLK          in   clock (parallel-data clock of the oscillator)
//   RESET        in   synchronous active-high reset
//   ENABLE       in   request to run the oscillator
//   TARGET_IN    in   [W]  requested period (clamped below at PERIOD_MIN)
//   STEP_IN      in   [W]  maximum period change per step (0 = single jump)
//   TARGET_VALID in   TARGET_IN/STEP_IN valid
//   TARGET_READY out  a target can be accepted (IDLE or HOLD)
//   PERIOD_OUT   out  [W] registered period word to the oscillator
//   OSC_CE       out  registered oscillator clock enable
//   BUSY         out  ramp in progress
//   DONE         out  one-cycle pulse when the target is reached
module period_ramp_ctrl #(
    parameter int unsigned PERIOD_INT_PART  = 10,
    parameter int unsigned PERIOD_FRAC_PART = 20,
    parameter logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_RESET = 30'h0075_8000,
    parameter logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_MIN   = 30'h0020_0000,
    parameter int unsigned UPDATE_DIV       = 16
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic                                        ENABLE,
    input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] TARGET_IN,
    input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] STEP_IN,
    input  logic                                        TARGET_VALID,
    output logic                                        TARGET_READY,
    output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_OUT,
    output logic                                        OSC_CE,
    output logic                                        BUSY,
    output logic                                        DONE
);

    localparam int unsigned W  = PERIOD_INT_PART + PERIOD_FRAC_PART;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] TICK_LAST = CW'(UPDATE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    period_q, period_d;
    logic [W-1:0]    tgt_q, tgt_d;
    logic [W-1:0]    step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            osc_ce_q, osc_ce_d;
    logic            done_q, done_d;

    // Extended copies: one spare bit keeps difference and step math free of wrap.
    logic [W:0]      tgt_x, per_x, step_x, diff_x;
    logic            up;
    logic            transfer;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            period_q <= PERIOD_RESET;
            tgt_q    <= PERIOD_RESET;
            step_q   <= '0;
            cnt_q    <= '0;
            osc_ce_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            osc_ce_q <= osc_ce_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        osc_ce_d = ENABLE & (state_q != IDLE);

        transfer = TARGET_VALID & (state_q != RAMP);
        tgt_x    = {1'b0, tgt_q};
        per_x    = {1'b0, period_q};
        step_x   = {1'b0, step_q};
        up       = tgt_q > period_q;
        diff_x   = up ? (tgt_x - per_x) : (per_x - tgt_x);

        case (state_q)
            IDLE, HOLD: begin
                if (transfer) begin
                    tgt_d   = (TARGET_IN < PERIOD_MIN) ? PERIOD_MIN : TARGET_IN;
                    step_d  = STEP_IN;
                    cnt_d   = '0;
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (cnt_q == TICK_LAST) begin
                    cnt_d = '0;
                    // Land exactly on the target once it is within one step.
                    if ((step_q == '0) || (diff_x <= step_x)) begin
                        period_d = tgt_q;
                        state_d  = HOLD;
                        done_d   = 1'b1;
                    end else if (up) begin
                        period_d = W'(per_x + step_x);
                    end else begin
                        period_d = W'(per_x - step_x);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TARGET_READY = (state_q != RAMP);
    assign BUSY         = (state_q == RAMP);
    assign PERIOD_OUT   = period_q;
    assign OSC_CE       = osc_ce_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_period_ramp_ctrl.sv
// tb_period_ramp_ctrl: scoreboard bench for period_ramp_ctrl. A reference
// model expands each accepted target into the expected sequence of period
// words; the sequence is queued at transfer and popped at every ramp tick.
module tb_period_ramp_ctrl;

    localparam int unsigned W   = 30;
    localparam int unsigned DIV = 4;
    localparam logic [W-1:0] P_RESET = 30'h0075_8000;
    localparam logic [W-1:0] P_MIN   = 30'h0020_0000;

    typedef struct {
        logic [W-1:0] period;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] target_in;
    logic [W-1:0] step_in;
    logic         target_valid;
    logic         target_ready;
    logic [W-1:0] period_out;
    logic         osc_ce;
    logic         busy;
    logic         done;

    exp_t         exp_q[$];
    longint       model_period;
    int           n_checks = 0;
    int           n_fail   = 0;

    period_ramp_ctrl #(
        .PERIOD_INT_PART (10),
        .PERIOD_FRAC_PART(20),
        .PERIOD_RESET    (P_RESET),
        .PERIOD_MIN      (P_MIN),
        .UPDATE_DIV      (DIV)
    ) dut (
        .CLK         (clk),
        .RESET       (reset),
        .ENABLE      (enable),
        .TARGET_IN   (target_in),
        .STEP_IN     (step_in),
        .TARGET_VALID(target_valid),
        .TARGET_READY(target_ready),
        .PERIOD_OUT  (period_out),
        .OSC_CE      (osc_ce),
        .BUSY        (busy),
        .DONE        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expand target/step into the expected period sequence.
    task automatic model_push(input longint tgt_raw, input longint st);
        longint t, cur, d;
        t   = (tgt_raw < longint'(P_MIN)) ? longint'(P_MIN) : tgt_raw;
        cur = model_period;
        forever begin
            d = (t > cur) ? t - cur : cur - t;
            if (st == 0 || d <= st) begin
                exp_q.push_back('{period: W'(t), last: 1'b1});
                break;
            end
            cur = (t > cur) ? cur + st : cur - st;
            exp_q.push_back('{period: W'(cur), last: 1'b0});
        end
        model_period = t;
    endtask

    // Present a target, then follow the ramp tick by tick against the queue.
    // poke: pulse TARGET_VALID mid-ramp with a different target (must be ignored).
    task automatic run_ramp(input logic [W-1:0] tgt, input logic [W-1:0] st, input bit poke);
        exp_t e;
        logic [W-1:0] held;
        bit first;
        check("ready_before", target_ready, 1'b1);
        model_push(longint'(tgt), longint'(st));
        target_in    = tgt;
        step_in      = st;
        target_valid = 1'b1;
        step_clk();
        target_valid = 1'b0;
        check("busy_after_xfer", busy, 1'b1);
        check("ready_in_ramp", target_ready, 1'b0);
        first = 1'b1;
        while (exp_q.size() > 0) begin
            held = period_out;
            for (int k = 1; k <= int'(DIV); k++) begin
                if (poke && first && k == 2) begin
                    target_in    = 30'h0300_0000;
                    step_in      = 30'h0000_0000;
                    target_valid = 1'b1;
                end
                step_clk();
                target_valid = 1'b0;
                if (first && k == 1 && enable) check("osc_ce_after_xfer", osc_ce, 1'b1);
                if (k < int'(DIV)) begin
                    check("period_between_ticks", period_out, held);
                    check("busy_between_ticks", busy, 1'b1);
                end
            end
            e = exp_q.pop_front();
            check("period_at_tick", period_out, e.period);
            check("done_at_tick", done, e.last);
            check("busy_at_tick", busy, !e.last);
            first = 1'b0;
        end
        step_clk();
        check("done_one_cycle", done, 1'b0);
        check("ready_in_hold", target_ready, 1'b1);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        target_in    = '0;
        step_in      = '0;
        target_valid = 1'b0;
        model_period = longint'(P_RESET);
        step_clk();
        step_clk();
        reset = 1'b0;

        // Reset state
        check("rst_period", period_out, P_RESET);
        check("rst_osc_ce", osc_ce, 1'b0);
        check("rst_ready", target_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // Enabled with no target: oscillator stays off, period unchanged
        enable = 1'b1;
        for (int i = 0; i < 10; i++) step_clk();
        check("idle_period", period_out, P_RESET);
        check("idle_osc_ce", osc_ce, 1'b0);
        check("idle_ready", target_ready, 1'b1);

        // Upward ramp 7.34375 -> 8.0 in 0.25 steps
        run_ramp(30'h0080_0000, 30'h0004_0000, 1'b0);
        check("up_final", period_out, 30'h0080_0000);
        check("up_osc_ce", osc_ce, 1'b1);

        // Downward ramp to 1.0 clamps at 2.0
        run_ramp(30'h0010_0000, 30'h0010_0000, 1'b0);
        check("down_clamped", period_out, 30'h0020_0000);

        // Zero step: single jump at first tick; mid-ramp valid is ignored
        run_ramp(30'h00A0_0000, 30'h0000_0000, 1'b1);
        check("jump_final", period_out, 30'h00A0_0000);

        // Target equal to current period still completes one tick later
        run_ramp(30'h00A0_0000, 30'h0001_0000, 1'b0);

        // ENABLE gates OSC_CE with one cycle latency in HOLD
        enable = 1'b0;
        step_clk();
        check("osc_ce_off", osc_ce, 1'b0);
        enable = 1'b1;
        step_clk();
        check("osc_ce_on", osc_ce, 1'b1);

        // Random ramps
        for (int r = 0; r < 3; r++) begin
            run_ramp(W'($urandom_range(32'h0200_0000, 32'h0)),
                     W'($urandom_range(32'h0040_0000, 32'h0010_0000)), 1'b0);
        end

        // RESET mid-ramp abandons the ramp
        target_in    = 30'h00F0_0000;
        step_in      = 30'h0000_1000;
        target_valid = 1'b1;
        step_clk();
        target_valid = 1'b0;
        for (int i = 0; i < int'(DIV) + 1; i++) step_clk();
        check("pre_rst_busy", busy, 1'b1);
        reset        = 1'b1;
        target_valid = 1'b1;
        step_clk();
        reset        = 1'b0;
        target_valid = 1'b0;
        check("midrst_period", period_out, P_RESET);
        check("midrst_busy", busy, 1'b0);
        check("midrst_osc_ce", osc_ce, 1'b0);
        check("midrst_ready", target_ready, 1'b1);
        step_clk();
        check("midrst_idle_osc", osc_ce, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
